// File: rtl/pd_inout_pipe.sv
// pd_inout_pipe: XOR/select stage of the F0F1 datapath plus a stallable, flushable
// delay pipeline that returns R to the PD mux.
//   - out_f is purely combinational: sel ? (in_r9 ^ in_f) : in_pd_mux.
//   - R travels through DEPTH registered stages, each with its own valid bit.
//   - occupancy is a registered up/down counter that tracks how many stages are valid.
module pd_inout_pipe #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 3,
  parameter bit          ZERO_INVALID = 1'b0,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_r9,
  input  logic [WIDTH-1:0] in_f,
  input  logic [WIDTH-1:0] in_pd_mux,
  input  logic             sel,
  input  logic             in_valid,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] out_f,
  output logic [WIDTH-1:0] out_pd,
  output logic             out_pd_valid,
  output logic [CW-1:0]    occupancy,
  output logic             full
);

  // Reject unsupported depths at elaboration time.
  if (DEPTH < 1 || DEPTH > 8) begin : gen_depth_check
    $error("pd_inout_pipe: DEPTH must be in 1..8");
  end

  logic [WIDTH-1:0] r;

  // Per-stage data, valid bits and the occupancy counter.
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    occ_d;

  assign r     = in_r9 ^ in_f;
  assign out_f = sel ? r : in_pd_mux;

  // Next-state: flush beats advance, advance beats hold.
  always_comb begin
    d_d   = d_q;
    v_d   = v_q;
    occ_d = occ_q;
    if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d_d[k] = '0;
      end
      v_d   = '0;
      occ_d = '0;
    end else if (en) begin
      // Data shifts regardless of validity; the valid bits alone qualify it.
      d_d[0] = r;
      v_d[0] = in_valid;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        d_d[k] = d_q[k-1];
        v_d[k] = v_q[k-1];
      end
      // Enter and leave in the same cycle cancel out.
      unique case ({in_valid, v_q[DEPTH-1]})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '{default: '0};
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      d_q   <= d_d;
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  // Outputs are derived only from registers.
  if (ZERO_INVALID) begin : gen_zero_invalid
    assign out_pd = v_q[DEPTH-1] ? d_q[DEPTH-1] : '0;
  end else begin : gen_raw_out
    assign out_pd = d_q[DEPTH-1];
  end

  assign out_pd_valid = v_q[DEPTH-1];
  assign occupancy    = occ_q;
  assign full         = (occ_q == CW'(DEPTH));

endmodule

// File: tb/tb_pd_inout_pipe.sv
// Self-checking bench for pd_inout_pipe: three instances (DEPTH 3/1/8) share one
// stimulus stream; each has a valid-bit stage model and a data scoreboard queue.
module tb_pd_inout_pipe;

  typedef logic [63:0] dq_t [$];

  typedef struct {
    logic [63:0] r9;
    logic [63:0] f;
    logic [63:0] pd;
    bit          sel;
    logic [63:0] exp;
  } fvec_t;

  typedef struct {
    bit          en;
    bit          iv;
    logic [31:0] r;
    bit          ev;
    logic [31:0] epd;
    logic [1:0]  eocc;
  } svec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, in_valid, en, flush;
  logic [63:0] in_r9, in_f, in_pd_mux;

  logic [31:0] o3_f, o3_pd;
  logic        o3_v, o3_full;
  logic [1:0]  o3_occ;
  logic [63:0] o1_f, o1_pd;
  logic        o1_v, o1_full;
  logic [0:0]  o1_occ;
  logic [63:0] o8_f, o8_pd;
  logic        o8_v, o8_full;
  logic [3:0]  o8_occ;

  int errors = 0;
  int checks = 0;

  logic [7:0] vm3 = '0, vm1 = '0, vm8 = '0;
  dq_t        q3, q1, q8;

  always #5 clk = ~clk;

  pd_inout_pipe #(.WIDTH(32), .DEPTH(3), .ZERO_INVALID(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_r9(in_r9[31:0]), .in_f(in_f[31:0]),
    .in_pd_mux(in_pd_mux[31:0]), .sel(sel), .in_valid(in_valid), .en(en), .flush(flush),
    .out_f(o3_f), .out_pd(o3_pd), .out_pd_valid(o3_v), .occupancy(o3_occ), .full(o3_full)
  );

  pd_inout_pipe #(.WIDTH(64), .DEPTH(1), .ZERO_INVALID(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_r9(in_r9), .in_f(in_f), .in_pd_mux(in_pd_mux),
    .sel(sel), .in_valid(in_valid), .en(en), .flush(flush),
    .out_f(o1_f), .out_pd(o1_pd), .out_pd_valid(o1_v), .occupancy(o1_occ), .full(o1_full)
  );

  pd_inout_pipe #(.WIDTH(64), .DEPTH(8), .ZERO_INVALID(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_r9(in_r9), .in_f(in_f), .in_pd_mux(in_pd_mux),
    .sel(sel), .in_valid(in_valid), .en(en), .flush(flush),
    .out_f(o8_f), .out_pd(o8_pd), .out_pd_valid(o8_v), .occupancy(o8_occ), .full(o8_full)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one instance's reference model by one clock edge.
  task automatic model_step(input int dep, input logic [63:0] dmask,
                            ref logic [7:0] vm, ref dq_t q);
    logic [63:0] r;
    logic [7:0]  smask;
    r     = (in_r9 ^ in_f) & dmask;
    smask = 8'hFF >> (8 - dep);
    if (!rst_n || flush) begin
      vm = '0;
      q.delete();
    end else if (en) begin
      if (vm[dep-1]) void'(q.pop_front());
      vm = ((vm << 1) | {7'b0, in_valid}) & smask;
      if (in_valid) q.push_back(r);
    end
  endtask

  task automatic model_reset();
    vm3 = '0; vm1 = '0; vm8 = '0;
    q3.delete(); q1.delete(); q8.delete();
  endtask

  task automatic check_inst(input string nm, input int dep, input bit zi,
                            input logic [7:0] vm, input dq_t q, input logic [63:0] dmask,
                            input logic [63:0] a_f, input logic [63:0] a_pd,
                            input logic [63:0] a_v, input logic [63:0] a_occ,
                            input logic [63:0] a_full);
    int          occ;
    logic [63:0] exp_f;
    occ   = $countones(vm);
    exp_f = (sel ? (in_r9 ^ in_f) : in_pd_mux) & dmask;
    chk({nm, " out_f"}, a_f, exp_f);
    chk({nm, " out_pd_valid"}, a_v, 64'(vm[dep-1]));
    chk({nm, " occupancy"}, a_occ, 64'(occ));
    chk({nm, " full"}, a_full, 64'(occ == dep));
    if (vm[dep-1]) begin
      if (q.size() == 0) chk({nm, " scoreboard empty"}, a_pd, 64'hx);
      else chk({nm, " out_pd data"}, a_pd, q[0]);
    end else if (zi) begin
      chk({nm, " out_pd zero when invalid"}, a_pd, 64'd0);
    end
  endtask

  task automatic check_all();
    check_inst("d3", 3, 1'b0, vm3, q3, 64'hFFFF_FFFF, 64'(o3_f), 64'(o3_pd), 64'(o3_v),
               64'(o3_occ), 64'(o3_full));
    check_inst("d1", 1, 1'b1, vm1, q1, '1, o1_f, o1_pd, 64'(o1_v), 64'(o1_occ), 64'(o1_full));
    check_inst("d8", 8, 1'b1, vm8, q8, '1, o8_f, o8_pd, 64'(o8_v), 64'(o8_occ), 64'(o8_full));
  endtask

  // One rising edge: update all models, then sample outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step(3, 64'hFFFF_FFFF, vm3, q3);
    model_step(1, '1, vm1, q1);
    model_step(8, '1, vm8, q8);
    #1;
    check_all();
  endtask

  task automatic drive(input bit e, input bit iv, input logic [63:0] r);
    en = e; in_valid = iv; in_r9 = r; in_f = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fvec_t ftab [5];
    svec_t stab [9];
    logic [1:0] fill_occ [6];

    ftab[0] = '{64'h0000_0000_A5A5_A5A5, 64'h0000_0000_0F0F_0F0F, 64'd0, 1'b1,
                64'h0000_0000_AAAA_AAAA};
    ftab[1] = '{64'h0000_0000_A5A5_A5A5, 64'h0000_0000_0F0F_0F0F, 64'h0000_0000_1234_5678,
                1'b0, 64'h0000_0000_1234_5678};
    ftab[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b1,
                64'hFEDC_BA98_7654_3210};
    ftab[3] = '{64'hDEAD_BEEF_0000_0000, 64'd0, 64'hCAFE_F00D_5555_AAAA, 1'b0,
                64'hCAFE_F00D_5555_AAAA};
    ftab[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF, 1'b1, 64'd0};

    // Stall: samples 1,2, two cycles with en=0 (valid input dropped), then 3,4.
    stab[0] = '{1'b1, 1'b1, 32'd1,  1'b0, 32'd0, 2'd1};
    stab[1] = '{1'b1, 1'b1, 32'd2,  1'b0, 32'd0, 2'd2};
    stab[2] = '{1'b0, 1'b1, 32'd99, 1'b0, 32'd0, 2'd2};
    stab[3] = '{1'b0, 1'b1, 32'd99, 1'b0, 32'd0, 2'd2};
    stab[4] = '{1'b1, 1'b1, 32'd3,  1'b1, 32'd1, 2'd3};
    stab[5] = '{1'b1, 1'b1, 32'd4,  1'b1, 32'd2, 2'd3};
    stab[6] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd3, 2'd2};
    stab[7] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd4, 2'd1};
    stab[8] = '{1'b1, 1'b0, 32'd0,  1'b0, 32'd0, 2'd0};

    fill_occ[0] = 2'd1; fill_occ[1] = 2'd2; fill_occ[2] = 2'd3;
    fill_occ[3] = 2'd3; fill_occ[4] = 2'd3; fill_occ[5] = 2'd2;

    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; en = 1'b0; flush = 1'b0;
    in_r9 = '0; in_f = '0; in_pd_mux = '0;
    #1;

    // Combinational out_f while reset is held.
    for (int i = 0; i < 5; i++) begin
      in_r9 = ftab[i].r9; in_f = ftab[i].f; in_pd_mux = ftab[i].pd; sel = ftab[i].sel;
      #1;
      chk($sformatf("out_f vec%0d d3", i), 64'(o3_f), ftab[i].exp & 64'hFFFF_FFFF);
      chk($sformatf("out_f vec%0d d1", i), o1_f, ftab[i].exp);
      chk($sformatf("out_f vec%0d d8", i), o8_f, ftab[i].exp);
    end
    chk("reset out_pd", 64'(o3_pd), 64'd0);
    chk("reset out_pd_valid", 64'(o3_v), 64'd0);
    chk("reset occupancy", 64'(o3_occ), 64'd0);
    check_all();

    @(negedge clk);
    rst_n = 1'b1; sel = 1'b1;

    // Latency: one valid sample, visible after the third edge only.
    drive(1'b1, 1'b1, 64'hDEAD_BEEF);
    cycle();
    chk("lat e0 valid", 64'(o3_v), 64'd0);
    chk("lat e0 occ", 64'(o3_occ), 64'd1);
    drive(1'b1, 1'b0, 64'd0);
    cycle();
    chk("lat e1 valid", 64'(o3_v), 64'd0);
    chk("lat e1 occ", 64'(o3_occ), 64'd1);
    cycle();
    chk("lat e2 valid", 64'(o3_v), 64'd1);
    chk("lat e2 data", 64'(o3_pd), 64'hDEAD_BEEF);
    chk("lat e2 occ", 64'(o3_occ), 64'd1);
    cycle();
    chk("lat e3 valid", 64'(o3_v), 64'd0);
    chk("lat e3 occ", 64'(o3_occ), 64'd0);

    // Stall sequence.
    for (int i = 0; i < 9; i++) begin
      drive(stab[i].en, stab[i].iv, 64'(stab[i].r));
      cycle();
      chk($sformatf("stall e%0d valid", i), 64'(o3_v), 64'(stab[i].ev));
      chk($sformatf("stall e%0d occ", i), 64'(o3_occ), 64'(stab[i].eocc));
      if (stab[i].ev) chk($sformatf("stall e%0d data", i), 64'(o3_pd), 64'(stab[i].epd));
    end

    // Fill to full, keep streaming, then drop in_valid for one cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i < 5), 64'(100 + i));
      cycle();
      chk($sformatf("fill e%0d occ", i), 64'(o3_occ), 64'(fill_occ[i]));
      chk($sformatf("fill e%0d full", i), 64'(o3_full), 64'(fill_occ[i] == 2'd3));
    end

    // Refill, then flush with en and in_valid both high.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 64'(200 + i));
      cycle();
    end
    chk("pre-flush full", 64'(o3_full), 64'd1);
    drive(1'b1, 1'b1, 64'h0BAD_F00D);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush occ", 64'(o3_occ), 64'd0);
    chk("flush valid", 64'(o3_v), 64'd0);
    chk("flush data", 64'(o3_pd), 64'd0);
    chk("flush full", 64'(o3_full), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 64'd0);
      cycle();
      chk($sformatf("post-flush e%0d valid", i), 64'(o3_v), 64'd0);
    end

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 64'(300 + i));
      cycle();
    end
    chk("pre-reset valid", 64'(o3_v), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async reset d3 data", 64'(o3_pd), 64'd0);
    chk("async reset d3 occ", 64'(o3_occ), 64'd0);
    chk("async reset d8 occ", 64'(o8_occ), 64'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Random sweep across all three instances.
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 9) < 8);
      in_valid  = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      sel       = 1'($urandom_range(0, 1));
      in_r9     = {$urandom, $urandom};
      in_f      = {$urandom, $urandom};
      in_pd_mux = {$urandom, $urandom};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
